// File: rtl/region_addr_translator_if.sv
// rtl/region_addr_translator_if.sv - config, request and response bundle for region_addr_translator
interface region_addr_translator_if #(
   parameter int NUM_REGIONS     = 8,
   parameter int LOG_ADDR_WIDTH  = 32,
   parameter int PHY_RAW_WIDTH   = 28,
   parameter int TAG_WIDTH       = 4,
   parameter int FAULT_CNT_WIDTH = 16
) ();
   localparam int IDX_W = $clog2(NUM_REGIONS);

   logic                       cfgWe;
   logic [IDX_W-1:0]           cfgIndex;
   logic [LOG_ADDR_WIDTH-1:0]  cfgLogBase;
   logic [LOG_ADDR_WIDTH-1:0]  cfgMask;
   logic [PHY_RAW_WIDTH-1:0]   cfgPhyBase;
   logic [4:0]                 cfgAttr;

   logic                       reqValid;
   logic                       reqReady;
   logic [LOG_ADDR_WIDTH-1:0]  reqAddr;
   logic [1:0]                 reqType;
   logic [TAG_WIDTH-1:0]       reqTag;

   logic                       rspValid;
   logic                       rspReady;
   logic [PHY_RAW_WIDTH+1:0]   rspPhyAddr;
   logic [1:0]                 rspMemType;
   logic [1:0]                 rspFault;
   logic [IDX_W-1:0]           rspRegion;
   logic [TAG_WIDTH-1:0]       rspTag;
   logic [FAULT_CNT_WIDTH-1:0] faultCount;

   modport slave (
      input  cfgWe, cfgIndex, cfgLogBase, cfgMask, cfgPhyBase, cfgAttr,
      input  reqValid, reqAddr, reqType, reqTag, rspReady,
      output reqReady, rspValid, rspPhyAddr, rspMemType, rspFault, rspRegion, rspTag, faultCount
   );

   modport master (
      output cfgWe, cfgIndex, cfgLogBase, cfgMask, cfgPhyBase, cfgAttr,
      output reqValid, reqAddr, reqType, reqTag, rspReady,
      input  reqReady, rspValid, rspPhyAddr, rspMemType, rspFault, rspRegion, rspTag, faultCount
   );
endinterface

// File: rtl/region_addr_translator.sv
// rtl/region_addr_translator.sv - programmable region table with permission check, two-stage pipeline
module region_addr_translator #(
   parameter int NUM_REGIONS       = 8,
   parameter int LOG_ADDR_WIDTH    = 32,
   parameter int PHY_RAW_WIDTH     = 28,
   parameter int TAG_WIDTH         = 4,
   parameter int RESET_DEFAULT_MAP = 1,
   parameter int FAULT_CNT_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   region_addr_translator_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_REGIONS);
   localparam logic [1:0] MMT_MEMORY  = 2'd0;
   localparam logic [1:0] MMT_IO      = 2'd1;
   localparam logic [1:0] MMT_ILLEGAL = 2'd2;

   // attr bits: [4] valid, [3] isIO, [2] isUncachable, [1] allowWrite, [0] allowExec
   logic [LOG_ADDR_WIDTH-1:0]  r_log_base [NUM_REGIONS];
   logic [LOG_ADDR_WIDTH-1:0]  r_mask     [NUM_REGIONS];
   logic [PHY_RAW_WIDTH-1:0]   r_phy_base [NUM_REGIONS];
   logic [4:0]                 r_attr     [NUM_REGIONS];

   logic                       r_s1_valid;
   logic [LOG_ADDR_WIDTH-1:0]  r_s1_addr;
   logic [1:0]                 r_s1_type;
   logic [TAG_WIDTH-1:0]       r_s1_tag;

   logic                       r_s2_valid;
   logic [PHY_RAW_WIDTH+1:0]   r_s2_phy;
   logic [1:0]                 r_s2_mmt;
   logic [1:0]                 r_s2_fault;
   logic [IDX_W-1:0]           r_s2_region;
   logic [TAG_WIDTH-1:0]       r_s2_tag;
   logic [FAULT_CNT_WIDTH-1:0] r_fault_cnt;

   logic                       w_adv;
   logic                       w_accept;
   logic                       w_hit;
   logic [IDX_W-1:0]           w_idx;
   logic [4:0]                 w_attr;
   logic [LOG_ADDR_WIDTH-1:0]  w_offset;
   logic [PHY_RAW_WIDTH-1:0]   w_raw;
   logic [1:0]                 w_fault;
   logic [PHY_RAW_WIDTH+1:0]   w_phy;
   logic [1:0]                 w_mmt;
   logic [IDX_W-1:0]           w_region;

   // S2 drains when empty or consumed; S1 can take a new request when empty or moving on
   assign w_adv        = !r_s2_valid || bus.rspReady;
   assign bus.reqReady = rst && (!r_s1_valid || w_adv);
   assign w_accept     = bus.reqValid && bus.reqReady;

   // region table: reset to the default map (or all invalid), one entry written per cfgWe
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGIONS; i++) begin
            r_log_base[i] <= '0;
            r_mask[i]     <= '0;
            r_phy_base[i] <= '0;
            r_attr[i]     <= '0;
         end
         if (RESET_DEFAULT_MAP != 0) begin
            r_log_base[0] <= LOG_ADDR_WIDTH'(32'h0000_0000);
            r_mask[0]     <= LOG_ADDR_WIDTH'(32'h0000_FFFF);
            r_phy_base[0] <= PHY_RAW_WIDTH'(28'h000_0000);
            r_attr[0]     <= 5'b10011;
            r_log_base[1] <= LOG_ADDR_WIDTH'(32'h8000_0000);
            r_mask[1]     <= LOG_ADDR_WIDTH'(32'h07FF_FFFF);
            r_phy_base[1] <= PHY_RAW_WIDTH'(28'h800_0000);
            r_attr[1]     <= 5'b10011;
            r_log_base[2] <= LOG_ADDR_WIDTH'(32'h9000_0000);
            r_mask[2]     <= LOG_ADDR_WIDTH'(32'h000F_FFFF);
            r_phy_base[2] <= PHY_RAW_WIDTH'(28'h010_0000);
            r_attr[2]     <= 5'b10110;
            r_log_base[3] <= LOG_ADDR_WIDTH'(32'h4000_0000);
            r_mask[3]     <= LOG_ADDR_WIDTH'(32'h0000_000F);
            r_phy_base[3] <= PHY_RAW_WIDTH'(28'h000_0000);
            r_attr[3]     <= 5'b11110;
            r_log_base[4] <= LOG_ADDR_WIDTH'(32'h4000_2000);
            r_mask[4]     <= LOG_ADDR_WIDTH'(32'h0000_0003);
            r_phy_base[4] <= PHY_RAW_WIDTH'(28'h000_2000);
            r_attr[4]     <= 5'b11110;
         end
      end else if (bus.cfgWe && (int'(bus.cfgIndex) < NUM_REGIONS)) begin
         r_log_base[bus.cfgIndex] <= bus.cfgLogBase;
         r_mask[bus.cfgIndex]     <= bus.cfgMask;
         r_phy_base[bus.cfgIndex] <= bus.cfgPhyBase;
         r_attr[bus.cfgIndex]     <= bus.cfgAttr;
      end
   end

   // lookup of the S1 address against the current table; scanning downwards lets the lowest index win
   always_comb begin
      w_hit = 1'b0;
      w_idx = '0;
      for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
         if (r_attr[i][4] && ((r_s1_addr & ~r_mask[i]) == (r_log_base[i] & ~r_mask[i]))) begin
            w_hit = 1'b1;
            w_idx = IDX_W'(i);
         end
      end
      w_attr   = r_attr[w_idx];
      w_offset = r_s1_addr & r_mask[w_idx];
      w_raw    = r_phy_base[w_idx] + PHY_RAW_WIDTH'(w_offset);
      w_region = w_hit ? w_idx : '0;
      if (r_s1_type == 2'b11) begin
         w_fault = 2'b11;
      end else if (!w_hit) begin
         w_fault = 2'b01;
      end else if ((r_s1_type == 2'b01 && !w_attr[1]) ||
                   (r_s1_type == 2'b10 && (!w_attr[0] || w_attr[3]))) begin
         w_fault = 2'b10;
      end else begin
         w_fault = 2'b00;
      end
      if (w_fault != 2'b00) begin
         w_phy = '0;
         w_mmt = MMT_ILLEGAL;
      end else begin
         w_phy = {w_attr[2], w_attr[3], w_raw};
         w_mmt = w_attr[3] ? MMT_IO : MMT_MEMORY;
      end
   end

   // S1: capture accepted requests, empty when the held request moves on
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_s1_valid <= 1'b0;
         r_s1_addr  <= '0;
         r_s1_type  <= '0;
         r_s1_tag   <= '0;
      end else if (w_accept) begin
         r_s1_valid <= 1'b1;
         r_s1_addr  <= bus.reqAddr;
         r_s1_type  <= bus.reqType;
         r_s1_tag   <= bus.reqTag;
      end else if (w_adv) begin
         r_s1_valid <= 1'b0;
      end
   end

   // S2: register the translation result and count faults; held untouched while stalled
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_s2_valid  <= 1'b0;
         r_s2_phy    <= '0;
         r_s2_mmt    <= '0;
         r_s2_fault  <= '0;
         r_s2_region <= '0;
         r_s2_tag    <= '0;
         r_fault_cnt <= '0;
      end else if (w_adv) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_phy    <= w_phy;
            r_s2_mmt    <= w_mmt;
            r_s2_fault  <= w_fault;
            r_s2_region <= w_region;
            r_s2_tag    <= r_s1_tag;
            if (w_fault != 2'b00 && r_fault_cnt != '1) begin
               r_fault_cnt <= r_fault_cnt + FAULT_CNT_WIDTH'(1);
            end
         end
      end
   end

   assign bus.rspValid   = r_s2_valid;
   assign bus.rspPhyAddr = r_s2_phy;
   assign bus.rspMemType = r_s2_mmt;
   assign bus.rspFault   = r_s2_fault;
   assign bus.rspRegion  = r_s2_region;
   assign bus.rspTag     = r_s2_tag;
   assign bus.faultCount = r_fault_cnt;
endmodule
